regex_instr_mem_responder: RTL and testbench
============================================

Name: regex_instr_mem_responder

Overview:
Responder side of the regex_cpu instruction-fetch interface (memory_valid / memory_addr / memory_ready / memory_data). It holds the compiled regex program in a synchronous-read RAM and serves fetch requests from N_PORTS regex_cpu_pipelined instances through a round-robin arbiter. A host load port writes program words before or between runs. It sits between the CPU array and the program loader.

Parameters:
N_PORTS, 2, number of CPU fetch ports served
MEMORY_WIDTH, 20, instruction word width (opcode + INSTRUCTION_DATA_WIDTH)
MEMORY_ADDR_WIDTH, 11, fetch/load address width
MEM_DEPTH, 2048, number of implemented words (<= 2**MEMORY_ADDR_WIDTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
memory_valid  in  N_PORTS  per-port fetch request (from CPU)
memory_addr  in  N_PORTS*MEMORY_ADDR_WIDTH  per-port fetch address; port p occupies slice p
memory_ready  out  N_PORTS  per-port grant, one-hot or zero
memory_data  out  N_PORTS*MEMORY_WIDTH  per-port instruction word, held between fetches
load_valid  in  1  host write request
load_addr  in  MEMORY_ADDR_WIDTH  host write address
load_data  in  MEMORY_WIDTH  host write word
load_ready  out  1  high when a write is accepted this cycle
busy  out  1  fetch in flight (state != IDLE)

Behaviour:
- Reset (rst=0, asynchronous): memory_ready=0, memory_data=0 on all ports, load_ready=0, busy=0, state=IDLE, rr pointer=0. RAM contents are not cleared. Reset asserted mid-fetch aborts the fetch, and no data is delivered.
- FSM states: IDLE, GRANT, RESP.
- IDLE: load_ready=1. If load_valid, write RAM[load_addr]<=load_data this cycle and stay in IDLE. Loads have priority, so no grant is issued in a cycle with load_valid. Otherwise, if any memory_valid is high, pick port g as the first requester at or after rr pointer (cyclic), latch g, issue the RAM read at memory_addr[g], and go to GRANT.
- GRANT: memory_ready[g]=1, registered and asserted for exactly one cycle. load_ready=0. Handshake completes on the edge where memory_valid[g] && memory_ready[g]. Go to RESP and set rr pointer to (g+1) mod N_PORTS. If memory_valid[g]=0 in GRANT (request withdrawn), return to IDLE and leave memory_data and the rr pointer unchanged.
- RESP: memory_data[g] <= RAM read word. The word is visible the cycle after the handshake and held until port g's next completed fetch; other ports' data is unchanged. Return to IDLE.
- Latency: request seen in IDLE -> ready 1 cycle later -> data 1 cycle after the handshake. Peak throughput is one fetch per 3 cycles.
- memory_ready is never high in two consecutive cycles. At most one bit is set at a time.
- The fetch address is sampled in IDLE. Address changes during GRANT are ignored.
- Simultaneous requests from all ports are served in rr order with no starvation: each port waits at most N_PORTS grants.
- A load arriving while a fetch is in flight waits with load_ready=0 until IDLE.
- Read-during-write to the same address cannot occur, because loads and fetches are mutually exclusive per cycle.

Optional Feature:
Macro REGEX_IMEM_BOUNDS_CHECK_EN.
- Defined: a fetch or load with addr >= MEM_DEPTH is still handshaked, but it returns memory_data=0 and does not write the RAM. It also sets the sticky output addr_error (1 bit), which is cleared only by reset.
- Undefined: there is no addr_error port, and the address is truncated to clog2(MEM_DEPTH) bits, so it aliases.

Decomposition:
- The shared regex package (instruction_package) holds the opcode enum (incl. SPLIT), INSTRUCTION_DATA_WIDTH, and the imem_state_t enum {IDLE, GRANT, RESP}.
- The round-robin arbiter is a natural sub-module: rr_arbiter (request vector, advance pulse -> one-hot grant + index).

Test Plan:
- Load RAM[245]={SPLIT, 0..0, 9'd12}. Port0 requests addr 245. Required response: memory_ready[0] is high exactly 1 cycle; memory_data[0] equals the word on the next cycle and is held for 10 idle cycles.
- Ports 0 and 1 request continuously at addrs 10 and 20 (RAM[10]=20'h1_0001, RAM[20]=20'h2_0002). Required response: grants alternate 0,1,0,1; each port receives its word; memory_ready is never high in consecutive cycles.
- Port0 requests addr 5 and drops memory_valid in the GRANT cycle. Required response: FSM returns to IDLE, memory_data[0] is unchanged, and the next grant still goes to port 0.
- load_valid and memory_valid[1] are asserted in the same IDLE cycle. Required response: the write occurs first, no grant is issued that cycle, and the grant follows 1 cycle later. A fetch of the just-written address returns the new data.
- Drive rst=0 in the GRANT cycle. Required response: memory_ready and memory_data clear immediately (asynchronously). After release, a fresh fetch works.
- With REGEX_IMEM_BOUNDS_CHECK_EN and MEM_DEPTH=256, fetch addr 300. Required response: the handshake completes, data=0, addr_error=1 and stays sticky.

Source files
------------

// File: rtl/regex_instr_mem_responder_pkg.sv
// Shared definitions for the regex instruction-memory responder.
//   - Instruction word layout: 4-bit opcode followed by INSTRUCTION_DATA_WIDTH
//     bits of operand data (20 bits total).
//   - opcode_t    : regex CPU opcodes, including SPLIT.
//   - imem_state_t: responder FSM states {IDLE, GRANT, RESP}.
//   - rr_next()   : cyclic successor of a port index.
package regex_instr_mem_responder_pkg;

  localparam int unsigned OPCODE_WIDTH           = 4;
  localparam int unsigned INSTRUCTION_DATA_WIDTH = 16;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_CHAR  = 4'd0,
    OP_ANY   = 4'd1,
    OP_SPLIT = 4'd2,
    OP_JMP   = 4'd3,
    OP_MATCH = 4'd4,
    OP_CLASS = 4'd5
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } imem_state_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regex_instr_mem_responder_if.sv
// Bus bundle between the regex CPU array / program loader (master) and the
// instruction-memory responder (slave).
//   memory_valid/addr : per-port fetch request, port p in slice p
//   memory_ready/data : per-port grant pulse and held instruction word
//   load_valid/addr/data, load_ready : host program-write port
//   busy              : fetch in flight
//   addr_error        : sticky out-of-range flag, present only when
//                       REGEX_IMEM_BOUNDS_CHECK_EN is defined
interface regex_instr_mem_responder_if #(
  parameter int unsigned N_PORTS           = 2,
  parameter int unsigned MEMORY_WIDTH      = 20,
  parameter int unsigned MEMORY_ADDR_WIDTH = 11
) ();
  logic [N_PORTS-1:0]                   memory_valid;
  logic [N_PORTS*MEMORY_ADDR_WIDTH-1:0] memory_addr;
  logic [N_PORTS-1:0]                   memory_ready;
  logic [N_PORTS*MEMORY_WIDTH-1:0]      memory_data;
  logic                                 load_valid;
  logic [MEMORY_ADDR_WIDTH-1:0]         load_addr;
  logic [MEMORY_WIDTH-1:0]              load_data;
  logic                                 load_ready;
  logic                                 busy;
`ifdef REGEX_IMEM_BOUNDS_CHECK_EN
  logic                                 addr_error;
`endif

  modport slave (
    input  memory_valid, memory_addr, load_valid, load_addr, load_data,
`ifdef REGEX_IMEM_BOUNDS_CHECK_EN
    output addr_error,
`endif
    output memory_ready, memory_data, load_ready, busy
  );

  modport master (
    output memory_valid, memory_addr, load_valid, load_addr, load_data,
`ifdef REGEX_IMEM_BOUNDS_CHECK_EN
    input  addr_error,
`endif
    input  memory_ready, memory_data, load_ready, busy
  );
endinterface

// File: rtl/regex_instr_mem_responder_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the rotating
// pointer. The pointer moves past the served port only when i_advance pulses.
//   clk, rst      : clock, asynchronous active-low reset (pointer -> 0)
//   i_req         : request vector
//   i_advance     : completed-service pulse
//   i_served_idx  : index of the port that was served
//   o_grant/o_idx : one-hot grant and its index; o_any when any request
module rr_arbiter
  import regex_instr_mem_responder_pkg::*;
#(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] i_req,
  input  logic               i_advance,
  input  logic [IDX_W-1:0]   i_served_idx,
  output logic [N_PORTS-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ptr <= '0;
    else if (i_advance) r_ptr <= IDX_W'(rr_next(32'(i_served_idx), N_PORTS));
  end

  always_comb begin
    logic [IDX_W-1:0] w_cand;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int unsigned off = 0; off < N_PORTS; off++) begin
      w_cand = IDX_W'((32'(r_ptr) + off) % N_PORTS);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regex_instr_mem_responder.sv
// Instruction-fetch responder for an array of regex CPUs. Holds the program
// in a synchronous-read RAM, serves per-port fetches through a round-robin
// arbiter (IDLE -> GRANT -> RESP) and accepts host program writes in IDLE.
//   clk, rst : clock, asynchronous active-low reset (RAM is not cleared)
//   bus      : regex_instr_mem_responder_if.slave (fetch + load ports, busy)
// Optional: REGEX_IMEM_BOUNDS_CHECK_EN adds a sticky addr_error flag and
// makes out-of-range fetches return 0 / out-of-range loads drop the write.
// Without it the address is truncated to clog2(MEM_DEPTH) bits and aliases.
module regex_instr_mem_responder
  import regex_instr_mem_responder_pkg::*;
#(
  parameter int unsigned N_PORTS           = 2,
  parameter int unsigned MEMORY_WIDTH      = 20,
  parameter int unsigned MEMORY_ADDR_WIDTH = 11,
  parameter int unsigned MEM_DEPTH         = 2048
) (
  input logic                         clk,
  input logic                         rst,
  regex_instr_mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [MEMORY_WIDTH-1:0]         r_ram [MEM_DEPTH];
  logic [MEMORY_WIDTH-1:0]         r_rd_word;
  imem_state_t                     r_state, w_state_nxt;
  logic [IDX_W-1:0]                r_gidx;
  logic [N_PORTS-1:0]              r_ready;
  logic [N_PORTS*MEMORY_WIDTH-1:0] r_data;

  logic                         w_any;
  logic [IDX_W-1:0]             w_req_idx;
  logic [N_PORTS-1:0]           w_req_grant;
  logic                         w_load_we, w_issue, w_handshake;
  logic [MEMORY_ADDR_WIDTH-1:0] w_fetch_addr;
  logic                         w_fetch_oob, w_load_oob;
  logic                         r_rd_oob;

  rr_arbiter #(.N_PORTS(N_PORTS), .IDX_W(IDX_W)) u_arb (
    .clk          (clk),
    .rst          (rst),
    .i_req        (bus.memory_valid),
    .i_advance    (w_handshake),
    .i_served_idx (r_gidx),
    .o_grant      (w_req_grant),
    .o_idx        (w_req_idx),
    .o_any        (w_any)
  );

  assign w_fetch_addr = bus.memory_addr[w_req_idx*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];

`ifdef REGEX_IMEM_BOUNDS_CHECK_EN
  logic r_addr_error;
  assign w_fetch_oob    = (32'(w_fetch_addr) >= MEM_DEPTH);
  assign w_load_oob     = (32'(bus.load_addr) >= MEM_DEPTH);
  assign bus.addr_error = r_addr_error;
`else
  assign w_fetch_oob = 1'b0;
  assign w_load_oob  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Loads win over fetches in IDLE, so RAM read and write never collide.
  always_comb begin
    w_state_nxt = r_state;
    w_load_we   = 1'b0;
    w_issue     = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.load_valid) begin
          w_load_we = 1'b1;
        end else if (w_any) begin
          w_issue     = 1'b1;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (bus.memory_valid[r_gidx]) begin
          w_handshake = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_load_we && !w_load_oob) r_ram[bus.load_addr[RAM_AW-1:0]] <= bus.load_data;
    if (w_issue) r_rd_word <= r_ram[w_fetch_addr[RAM_AW-1:0]];
  end

  // Data is written on the handshake edge so the word is visible during RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready  <= '0;
      r_data   <= '0;
      r_gidx   <= '0;
      r_rd_oob <= 1'b0;
`ifdef REGEX_IMEM_BOUNDS_CHECK_EN
      r_addr_error <= 1'b0;
`endif
    end else begin
      r_ready <= w_issue ? w_req_grant : '0;
      if (w_issue) begin
        r_gidx   <= w_req_idx;
        r_rd_oob <= w_fetch_oob;
      end
      if (w_handshake)
        r_data[r_gidx*MEMORY_WIDTH +: MEMORY_WIDTH] <= r_rd_oob ? '0 : r_rd_word;
`ifdef REGEX_IMEM_BOUNDS_CHECK_EN
      if ((w_handshake && r_rd_oob) || (w_load_we && w_load_oob)) r_addr_error <= 1'b1;
`endif
    end
  end

  assign bus.memory_ready = r_ready;
  assign bus.memory_data  = r_data;
  assign bus.busy         = (r_state != IDLE);
  assign bus.load_ready   = (r_state == IDLE) && rst;

endmodule

// File: tb/tb_regex_instr_mem_responder.sv
module tb_regex_instr_mem_responder;
  import regex_instr_mem_responder_pkg::*;

  localparam int unsigned NP  = 2;
  localparam int unsigned W   = 20;
  localparam int unsigned AW  = 11;
`ifdef REGEX_IMEM_BOUNDS_CHECK_EN
  localparam int unsigned DEPTH = 256;
`else
  localparam int unsigned DEPTH = 2048;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regex_instr_mem_responder_if #(.N_PORTS(NP), .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW)) bus ();

  regex_instr_mem_responder #(
    .N_PORTS(NP), .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: program memory, per-port delivered words, whose turn it
  // is next, which port is currently being offered a grant, and whether the
  // responder is in its post-delivery cool-down cycle.
  logic [W-1:0] m_mem [DEPTH];
  logic [W-1:0] m_data [NP];
  int           m_next;
  int           m_offer;
  bit           m_cool;
  logic [W-1:0] m_word;
  bit           m_word_oob;
  bit           m_err;
  logic [NP-1:0] prev_ready;

  function automatic bit oob(input logic [AW-1:0] a);
`ifdef REGEX_IMEM_BOUNDS_CHECK_EN
    return 32'(a) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) m_data[p] = '0;
    m_next = 0; m_offer = -1; m_cool = 0; m_err = 0; prev_ready = '0;
  endtask

  // One clock: drive inputs, advance the model, sample 1 ns after the edge.
  task automatic step(input logic [NP-1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic lv, input logic [AW-1:0] la, input logic [W-1:0] ld);
    logic [AW-1:0] addrs [NP];
    logic [NP-1:0] exp_ready;
    addrs[0] = a0; addrs[1] = a1;
    bus.memory_valid = v;
    bus.memory_addr  = {a1, a0};
    bus.load_valid   = lv;
    bus.load_addr    = la;
    bus.load_data    = ld;

    if (m_offer >= 0) begin
      if (v[m_offer]) begin
        m_data[m_offer] = m_word_oob ? '0 : m_word;
        if (m_word_oob) m_err = 1;
        m_next = (m_offer + 1) % NP;
        m_cool = 1;
      end
      m_offer = -1;
    end else if (m_cool) begin
      m_cool = 0;
    end else if (lv) begin
      if (oob(la)) m_err = 1;
      else m_mem[32'(la) % DEPTH] = ld;
    end else if (v != '0) begin
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (m_next + k) % NP;
        if (m_offer < 0 && v[p]) m_offer = p;
      end
      m_word_oob = oob(addrs[m_offer]);
      m_word     = m_word_oob ? '0 : m_mem[32'(addrs[m_offer]) % DEPTH];
    end

    @(posedge clk);
    #1;
    exp_ready = '0;
    if (m_offer >= 0) exp_ready[m_offer] = 1'b1;
    chk("ready", 64'(bus.memory_ready), 64'(exp_ready));
    chk("data", 64'(bus.memory_data), 64'({m_data[1], m_data[0]}));
    chk("busy", 64'(bus.busy), 64'(m_offer >= 0 || m_cool));
    chk("load_ready", 64'(bus.load_ready), 64'(!(m_offer >= 0 || m_cool)));
    chk("no_b2b_ready", 64'(prev_ready & bus.memory_ready), 64'(0));
    chk("onehot_ready", 64'($countones(bus.memory_ready) <= 1), 64'(1));
`ifdef REGEX_IMEM_BOUNDS_CHECK_EN
    chk("addr_error", 64'(bus.addr_error), 64'(m_err));
`endif
    prev_ready = bus.memory_ready;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, '0, '0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
`ifdef REGEX_IMEM_BOUNDS_CHECK_EN
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(DEPTH, 2**AW - 1));
`endif
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic pulse_reset();
    bus.memory_valid = '0; bus.load_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [W-1:0] w_split;
  int           prev_g;
  logic [W-1:0] p0_word;

  initial begin
    bus.memory_valid = '0; bus.memory_addr = '0;
    bus.load_valid = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    model_reset();
    #2;
    chk("rst_ready", 64'(bus.memory_ready), 64'(0));
    chk("rst_data", 64'(bus.memory_data), 64'(0));
    chk("rst_load_ready", 64'(bus.load_ready), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // Preload whole program memory.
    for (int a = 0; a < int'(DEPTH); a++) step('0, '0, '0, 1'b1, AW'(a), W'($urandom));

    // Single fetch of a SPLIT word, then hold for 10 idle cycles.
    w_split = {OP_SPLIT, 7'd0, 9'd12};
    step('0, '0, '0, 1'b1, AW'(245), w_split);
    step(2'b01, AW'(245), '0, 1'b0, '0, '0);
    chk("t1_ready_p0", 64'(bus.memory_ready), 64'(2'b01));
    step(2'b01, AW'(245), '0, 1'b0, '0, '0);
    chk("t1_ready_drop", 64'(bus.memory_ready), 64'(0));
    chk("t1_data", 64'(bus.memory_data[W-1:0]), 64'(w_split));
    idle(10);
    chk("t1_data_held", 64'(bus.memory_data[W-1:0]), 64'(w_split));

    // Both ports requesting continuously: grants alternate.
    step('0, '0, '0, 1'b1, AW'(10), 20'h1_0001);
    step('0, '0, '0, 1'b1, AW'(20), 20'h2_0002);
    prev_g = -1;
    for (int i = 0; i < 12; i++) begin
      step(2'b11, AW'(10), AW'(20), 1'b0, '0, '0);
      if (bus.memory_ready != '0) begin
        if (prev_g >= 0) chk("t2_alternate", 64'(bus.memory_ready[1]), 64'(prev_g == 0));
        prev_g = bus.memory_ready[1] ? 1 : 0;
      end
    end
    idle(2);
    chk("t2_p0_word", 64'(bus.memory_data[W-1:0]), 64'(20'h1_0001));
    chk("t2_p1_word", 64'(bus.memory_data[2*W-1:W]), 64'(20'h2_0002));

    // Make port 1 the last one served so port 0 is next in turn.
    step(2'b10, '0, AW'(30), 1'b0, '0, '0);
    step(2'b10, '0, AW'(30), 1'b0, '0, '0);
    idle(1);
    p0_word = 20'h1_0001;

    // Withdrawn request: no data, rr pointer unchanged.
    step(2'b01, AW'(5), '0, 1'b0, '0, '0);
    step(2'b00, AW'(5), '0, 1'b0, '0, '0);
    chk("t3_idle_after_wd", 64'(bus.busy), 64'(0));
    chk("t3_data_kept", 64'(bus.memory_data[W-1:0]), 64'(p0_word));
    step(2'b11, AW'(5), AW'(20), 1'b0, '0, '0);
    chk("t3_next_grant_p0", 64'(bus.memory_ready), 64'(2'b01));
    step(2'b11, AW'(5), AW'(20), 1'b0, '0, '0);
    idle(1);

    // Load and fetch in the same IDLE cycle: load first, grant one cycle later.
    step(2'b10, '0, AW'(77), 1'b1, AW'(77), 20'hA_BCDE);
    chk("t4_no_grant", 64'(bus.memory_ready), 64'(0));
    step(2'b10, '0, AW'(77), 1'b0, '0, '0);
    chk("t4_grant_p1", 64'(bus.memory_ready), 64'(2'b10));
    step(2'b10, '0, AW'(77), 1'b0, '0, '0);
    chk("t4_new_data", 64'(bus.memory_data[2*W-1:W]), 64'(20'hA_BCDE));
    idle(1);

    // Reset asserted during GRANT clears outputs immediately.
    step(2'b01, AW'(245), '0, 1'b0, '0, '0);
    rst = 1'b0;
    #1;
    chk("t5_ready_clr", 64'(bus.memory_ready), 64'(0));
    chk("t5_data_clr", 64'(bus.memory_data), 64'(0));
    chk("t5_busy_clr", 64'(bus.busy), 64'(0));
    chk("t5_load_ready_clr", 64'(bus.load_ready), 64'(0));
    model_reset();
    bus.memory_valid = '0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    step(2'b01, AW'(245), '0, 1'b0, '0, '0);
    step(2'b01, AW'(245), '0, 1'b0, '0, '0);
    chk("t5_fresh_fetch", 64'(bus.memory_data[W-1:0]), 64'(w_split));
    idle(1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [NP-1:0] v;
      logic lv;
      v  = NP'($urandom_range(0, 3));
      lv = ($urandom_range(0, 6) == 0);
      step(v, rand_addr(), rand_addr(), lv, rand_addr(), W'($urandom));
    end
    idle(2);

`ifdef REGEX_IMEM_BOUNDS_CHECK_EN
    pulse_reset();
    chk("t6_err_clear", 64'(bus.addr_error), 64'(0));
    step(2'b01, AW'(300), '0, 1'b0, '0, '0);
    chk("t6_grant", 64'(bus.memory_ready), 64'(2'b01));
    step(2'b01, AW'(300), '0, 1'b0, '0, '0);
    chk("t6_data_zero", 64'(bus.memory_data[W-1:0]), 64'(0));
    chk("t6_err_set", 64'(bus.addr_error), 64'(1));
    idle(5);
    chk("t6_err_sticky", 64'(bus.addr_error), 64'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
